// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins by default; a fetch is guaranteed a grant after MAX_D_STREAK data grants.
module mem_port_arbiter #(
    parameter int XLEN         = 64,
    parameter int ADDR_W       = 64,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_valid,
    output logic              stall_if,
    output logic              stall_d,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic              err,
    output logic [1:0]        state_dbg
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   d_streak;
    logic [TW-1:0]   timer;
    logic            flush_pend;
    logic            grant_d;
    logic            grant_i;
    logic            fetch_dropped;

    // Handshake: a requester holds req (and its address/data) until its
    // one-cycle valid pulse; memory completes a transaction when mem_ready is
    // seen while mem_req=1, and mem_ready at any other time is ignored.
    // In the cycle a requester's valid pulses it is not eligible for a grant.
    assign grant_d = (state == IDLE) && d_req && !d_valid &&
                     ((d_streak < STREAK_MAX) || !if_req);
    assign grant_i = (state == IDLE) && !grant_d && if_req && !if_valid && !if_flush;

    // A flush in the current cycle suppresses a completion arriving in the same cycle.
    assign fetch_dropped = flush_pend || if_flush;

    assign stall_if  = if_req & ~if_valid;
    assign stall_d   = d_req & ~d_valid;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            if_valid   <= 1'b0;
            d_rdata    <= '0;
            d_valid    <= 1'b0;
            err        <= 1'b0;
            d_streak   <= '0;
            timer      <= '0;
            flush_pend <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;

            if (!if_req) begin
                d_streak <= '0;
            end else if (grant_d) begin
                if (d_streak < STREAK_MAX) begin
                    d_streak <= d_streak + SW'(1);
                end
            end else if (grant_i) begin
                d_streak <= '0;
            end

            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        timer     <= '0;
                    end else if (grant_i) begin
                        state      <= BUSY_I;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        timer      <= '0;
                        flush_pend <= 1'b0;
                    end
                end

                BUSY_I: begin
                    if (if_flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_ready) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        flush_pend <= 1'b0;
                        if (!fetch_dropped) begin
                            if_rdata <= mem_rdata[31:0];
                            if_valid <= 1'b1;
                        end
                    end else if (timer == TMO_LAST) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        flush_pend <= 1'b0;
                        err        <= 1'b1;
                        if (!fetch_dropped) begin
                            if_rdata <= '0;
                            if_valid <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                BUSY_D: begin
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        d_rdata <= mem_rdata;
                        d_valid <= 1'b1;
                    end else if (timer == TMO_LAST) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        d_rdata <= '0;
                        d_valid <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, contention, streak guard, flush,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 64;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [XLEN-1:0]   d_rdata;
    logic              d_valid;
    logic              stall_if;
    logic              stall_d;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ready;
    logic              err;
    logic [1:0]        state_dbg;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_D_STREAK(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_if(stall_if), .stall_d(stall_d),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        step(); step();
        chk("rst_state", 64'(state_dbg), 64'(S_IDLE));
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        chk("rst_valid_err", 64'({if_valid, d_valid, err}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single load with minimum latency
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
        step();
        chk("ld_state", 64'(state_dbg), 64'(S_BUSY_D));
        chk("ld_mem_req", 64'(mem_req), 64'd1);
        chk("ld_mem_addr", mem_addr, 64'h100);
        chk("ld_mem_we", 64'(mem_we), 64'd0);
        chk("ld_stall_d", 64'(stall_d), 64'd1);
        mem_ready = 1'b1; mem_rdata = 64'hDEAD;
        step();
        chk("ld_d_valid", 64'(d_valid), 64'd1);
        chk("ld_d_rdata", d_rdata, 64'hDEAD);
        chk("ld_mem_req_low", 64'(mem_req), 64'd0);
        chk("ld_stall_d_low", 64'(stall_d), 64'd0);
        d_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("ld_d_valid_pulse", 64'(d_valid), 64'd0);

        // Contention: data first, fetch right after, 3-cycle memory
        if_req = 1'b1; if_addr = 64'h0; d_req = 1'b1; d_addr = 64'h200;
        step();
        chk("ct_state_d", 64'(state_dbg), 64'(S_BUSY_D));
        chk("ct_addr_d", mem_addr, 64'h200);
        chk("ct_stall_if", 64'(stall_if), 64'd1);
        step(); step();
        mem_ready = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
        step();
        chk("ct_d_valid", 64'(d_valid), 64'd1);
        chk("ct_d_rdata", d_rdata, 64'h1111_2222_3333_4444);
        d_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("ct_state_i", 64'(state_dbg), 64'(S_BUSY_I));
        chk("ct_addr_i", mem_addr, 64'h0);
        chk("ct_we_i", 64'(mem_we), 64'd0);
        step(); step();
        mem_ready = 1'b1; mem_rdata = 64'hAAAA_BBBB_1234_5678;
        step();
        chk("ct_if_valid", 64'(if_valid), 64'd1);
        chk("ct_if_rdata", 64'(if_rdata), 64'h1234_5678);
        if_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("ct_if_valid_pulse", 64'(if_valid), 64'd0);

        // Streak guard: fetch kept out of each blackout cycle by a redirect,
        // so only the guard lets it in after four data grants.
        if_req = 1'b1; if_addr = 64'h80; d_req = 1'b1; d_we = 1'b1;
        mem_ready = 1'b1; mem_rdata = 64'hCAFE_F00D;
        for (int r = 0; r < 4; r++) begin
            d_addr = 64'h300 + 64'(r * 8); d_wdata = 64'h55 + 64'(r);
            step();
            chk("sg_state_d", 64'(state_dbg), 64'(S_BUSY_D));
            chk("sg_addr_d", mem_addr, 64'h300 + 64'(r * 8));
            chk("sg_wdata_d", mem_wdata, 64'h55 + 64'(r));
            step();
            chk("sg_d_valid", 64'(d_valid), 64'd1);
            if_flush = 1'b1;
            step();
            chk("sg_idle_gap", 64'(state_dbg), 64'(S_IDLE));
            if_flush = 1'b0;
        end
        chk("sg_stall_if", 64'(stall_if), 64'd1);
        step();
        chk("sg_fetch_grant", 64'(state_dbg), 64'(S_BUSY_I));
        chk("sg_fetch_addr", mem_addr, 64'h80);
        step();
        chk("sg_if_valid", 64'(if_valid), 64'd1);
        chk("sg_if_rdata", 64'(if_rdata), 64'hCAFE_F00D);
        chk("sg_stall_if_low", 64'(stall_if), 64'd0);
        if_req = 1'b0;
        step();
        chk("sg_data_resume", 64'(state_dbg), 64'(S_BUSY_D));
        step();
        chk("sg_resume_valid", 64'(d_valid), 64'd1);
        d_req = 1'b0; mem_ready = 1'b0;
        step();

        // Flush while a fetch is in flight
        if_req = 1'b1; if_addr = 64'h40;
        step();
        chk("fl_state", 64'(state_dbg), 64'(S_BUSY_I));
        if_flush = 1'b1;
        step();
        if_flush = 1'b0; if_req = 1'b0;
        step();
        mem_ready = 1'b1; mem_rdata = 64'h9999_9999;
        step();
        chk("fl_no_valid", 64'(if_valid), 64'd0);
        chk("fl_rdata_kept", 64'(if_rdata), 64'hCAFE_F00D);
        chk("fl_idle", 64'(state_dbg), 64'(S_IDLE));
        chk("fl_mem_req", 64'(mem_req), 64'd0);
        mem_ready = 1'b0;
        step();
        chk("fl_no_valid_late", 64'(if_valid), 64'd0);

        // Timeout of a store: 16 BUSY cycles then abort
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h500; d_wdata = 64'h1234;
        step();
        chk("to_mem_req", 64'(mem_req), 64'd1);
        chk("to_mem_wdata", mem_wdata, 64'h1234);
        for (int k = 0; k < 15; k++) begin
            step();
            chk("to_hold", 64'({mem_req, err, d_valid}), 64'b100);
        end
        step();
        chk("to_abort_mem_req", 64'(mem_req), 64'd0);
        chk("to_d_valid", 64'(d_valid), 64'd1);
        chk("to_err", 64'(err), 64'd1);
        chk("to_d_rdata", d_rdata, 64'd0);
        d_req = 1'b0;
        step();
        chk("to_err_pulse", 64'({err, d_valid}), 64'd0);

        // Asynchronous reset in the middle of a data transaction
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h600;
        step();
        chk("ar_busy", 64'(state_dbg), 64'(S_BUSY_D));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_mem_req", 64'(mem_req), 64'd0);
        chk("ar_state", 64'(state_dbg), 64'(S_IDLE));
        chk("ar_d_valid", 64'(d_valid), 64'd0);
        chk("ar_mem_addr", mem_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ar_regrant", 64'(state_dbg), 64'(S_BUSY_D));
        chk("ar_regrant_addr", mem_addr, 64'h600);
        mem_ready = 1'b1; mem_rdata = 64'h7777;
        step();
        chk("ar_d_valid_after", 64'(d_valid), 64'd1);
        chk("ar_d_rdata_after", d_rdata, 64'h7777);
        d_req = 1'b0; mem_ready = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified instruction/data memory between the pipeline's fetch stage and its data-access stage (MemRead/MemWrite). It sequences every memory transaction through a small FSM, prioritises data accesses with a fetch anti-starvation guard, and drives per-requester stall signals. It discards flushed fetches on branch/jump redirect and aborts hung transactions on timeout.

Parameters:
XLEN, 64, data width
ADDR_W, 64, address width
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits (>=1)
TIMEOUT, 16, cycles in BUSY without mem_ready before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_valid or if_flush
if_addr  in  ADDR_W  fetch address, stable while if_req
if_flush  in  1  redirect pulse; drops any pending or in-flight fetch
if_rdata  out  32  fetched instruction, registered
if_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  data request (MemRead|MemWrite), held until d_valid
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  XLEN  store data
d_rdata  out  XLEN  load data, registered
d_valid  out  1  one-cycle data completion pulse (loads and stores)
stall_if  out  1  if_req & ~if_valid
stall_d  out  1  d_req & ~d_valid
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  latched address
mem_wdata  out  XLEN  latched store data
mem_rdata  in  XLEN  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, honoured only while mem_req=1
err  out  1  one-cycle timeout pulse, coincident with the aborted requester's valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, if_valid, d_valid, err=0; mem_addr, mem_wdata, if_rdata, d_rdata=0; d_streak, timer=0, flush_pend=0. mem_req drops immediately even mid-transaction; no completion reported.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE grant rule, evaluated each cycle:
  - d_req and (d_streak<MAX_D_STREAK or ~if_req) -> BUSY_D.
  - Else if_req and ~if_flush -> BUSY_I.
  - Requester whose valid pulses this cycle is ignored (one-cycle blackout).
- On grant: latch addr, wdata (data only) and we (fetch: mem_we=0); set mem_req=1 next cycle; timer=0.
- d_streak: +1 per data grant while if_req=1, saturating at MAX_D_STREAK; cleared on fetch grant or when if_req=0.
- BUSY_x with mem_ready=1: mem_req=0; capture mem_rdata (fetch: low 32 bits) into x_rdata; x_valid=1 for the next cycle; return to IDLE.
- Minimum latency: grant at cycle N, mem_req at N+1, mem_ready at N+1 -> valid at N+2.
- Timeout: timer increments each BUSY cycle without mem_ready. When timer reaches TIMEOUT-1 without ready: abort, mem_req=0, x_valid=1 and err=1 next cycle, x_rdata=0, -> IDLE.
- Flush:
  - if_flush in BUSY_I sets flush_pend. The transaction completes on memory, but if_valid is suppressed and if_rdata unchanged.
  - flush_pend clears on leaving BUSY_I.
  - if_flush in IDLE blocks a fetch grant that cycle.
  - if_flush never affects data transactions.
- mem_ready while mem_req=0 is ignored.
- Address and wdata arithmetic: none; passed through at full width.

Test Plan:
- Single load: d_req=1, d_we=0, d_addr=0x100; memory readies 1 cycle after mem_req with 0xDEAD -> mem_req high 1 cycle, d_valid at grant+2, d_rdata=0xDEAD, stall_d high until then.
- Contention: if_req and d_req asserted together at 0x0/0x200 -> data served first; fetch granted in the IDLE cycle after d_valid; if_valid follows 2 cycles later with 3-cycle memory.
- Starvation guard, MAX_D_STREAK=4: d_req held continuously with if_req=1 -> exactly 4 data grants, then 1 fetch grant, then data resumes.
- Flush in flight: fetch at 0x40 granted, if_flush pulsed next cycle, memory readies 2 cycles later -> no if_valid, if_rdata unchanged, FSM back in IDLE.
- Timeout, TIMEOUT=16: store granted, mem_ready never asserted -> after 16 BUSY cycles mem_req=0; d_valid=1 and err=1 together for one cycle.
- Async reset mid-BUSY_D: rst_n low between clock edges -> mem_req, d_valid=0 immediately; after release, a new d_req is served normally.
